// File: rtl/mul_eval_pkg.sv
// Shared types, default widths and helpers for the multiplier error-evaluation blocks.
// Sibling evaluators import this package so state encoding and widths stay consistent.
package mul_eval_pkg;

   localparam int W_DEF     = 8;
   localparam int CNT_W_DEF = 24;
   localparam int ACC_W_DEF = 40;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Unsigned |x - y|; the result always fits because both inputs are below 2^(2W).
   function automatic logic [2*W_DEF-1:0] abs_diff(input logic [2*W_DEF-1:0] x,
                                                   input logic [2*W_DEF-1:0] y);
      return (x >= y) ? (x - y) : (y - x);
   endfunction

endpackage

// File: rtl/mul8_exact_ref.sv
// Purely combinational exact W x W reference multiplier.
// Kept standalone so the reference product can be swapped or reused by sibling evaluators.
module mul8_exact_ref #(
   parameter int W = 8
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);

   assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/mul8_err_monitor.sv
// Error-characterisation stage behind an 8x8 approximate multiplier: recomputes the exact
// product per sample and accumulates sum of |error|, worst-case error and erroneous-sample count.
module mul8_err_monitor
   import mul_eval_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [2*W-1:0]   p_approx,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] sum_abs_err,
   output logic [2*W-1:0]   max_err,
   output logic [W-1:0]     max_a,
   output logic [W-1:0]     max_b,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] sample_count
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] target;
   logic             hs;
   logic             start_ok;
   logic             pipe_empty;

   logic             s1_valid, s2_valid;
   logic [W-1:0]     s1_a, s1_b, s2_a, s2_b;
   logic [2*W-1:0]   s1_p, s2_err, exact;
   logic [ACC_W:0]   sum_ext;

   // in_ready drops combinationally once the target is reached, so a held valid is refused.
   assign in_ready   = (state == RUN) && (sample_count < target);
   assign hs         = in_valid && in_ready;
   assign pipe_empty = !s1_valid && !s2_valid;
   assign busy       = (state == RUN);
   assign done       = (state == DONE);

   mul8_exact_ref #(.W(W)) u_exact_ref (
      .a (s1_a),
      .b (s1_b),
      .p (exact)
   );

   // One extra bit catches the carry that triggers saturation.
   assign sum_ext = {1'b0, sum_abs_err} + {{(ACC_W + 1 - 2*W){1'b0}}, s2_err};

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = RUN;
               start_ok  = 1'b1;
            end
         end
         RUN: begin
            if ((sample_count == target) && pipe_empty) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         target       <= '0;
         s1_valid     <= 1'b0;
         s2_valid     <= 1'b0;
         sum_abs_err  <= '0;
         max_err      <= '0;
         max_a        <= '0;
         max_b        <= '0;
         err_count    <= '0;
         sample_count <= '0;
      end else begin
         state    <= state_nxt;
         s1_valid <= hs;
         s2_valid <= s1_valid;
         if (start_ok) begin
            target       <= num_samples;
            sum_abs_err  <= '0;
            max_err      <= '0;
            max_a        <= '0;
            max_b        <= '0;
            err_count    <= '0;
            sample_count <= '0;
         end else begin
            if (hs) sample_count <= sample_count + CNT_W'(1);
            if (s2_valid) begin
               sum_abs_err <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
               if (s2_err != '0) err_count <= err_count + CNT_W'(1);
               // Strictly greater: on ties the earliest sample keeps its operands.
               if (s2_err > max_err) begin
                  max_err <= s2_err;
                  max_a   <= s2_a;
                  max_b   <= s2_b;
               end
            end
         end
      end
   end

   // NOTE: datapath registers carry no reset; their valid bits gate every use of them.
   always_ff @(posedge clk) begin
      if (hs) begin
         s1_a <= a;
         s1_b <= b;
         s1_p <= p_approx;
      end
      if (s1_valid) begin
         s2_a   <= s1_a;
         s2_b   <= s1_b;
         s2_err <= abs_diff(exact, s1_p);
      end
   end

endmodule

// File: tb/tb_mul8_err_monitor.sv
// Scoreboard bench for mul8_err_monitor: campaigns push expected statistics, a monitor
// pops and compares them whenever done rises.
module tb_mul8_err_monitor;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, in_ready;
   logic [23:0] num_samples;
   logic [7:0]  a, b;
   logic [15:0] p_approx;
   logic        busy, done;
   logic [39:0] sum_abs_err;
   logic [15:0] max_err;
   logic [7:0]  max_a, max_b;
   logic [23:0] err_count, sample_count;

   typedef struct {
      logic [39:0] sum;
      logic [15:0] max_err;
      logic [7:0]  max_a;
      logic [7:0]  max_b;
      logic [23:0] err_count;
      logic [23:0] sample_count;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks    = 0;
   int   failures  = 0;
   bit   done_prev = 1'b0;

   mul8_err_monitor dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .num_samples  (num_samples),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .a            (a),
      .b            (b),
      .p_approx     (p_approx),
      .busy         (busy),
      .done         (done),
      .sum_abs_err  (sum_abs_err),
      .max_err      (max_err),
      .max_a        (max_a),
      .max_b        (max_b),
      .err_count    (err_count),
      .sample_count (sample_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [39:0] s, input logic [15:0] m,
                               input logic [7:0] ma, input logic [7:0] mb,
                               input logic [23:0] ec, input logic [23:0] sc);
      exp_t e;
      e.sum = s; e.max_err = m; e.max_a = ma; e.max_b = mb;
      e.err_count = ec; e.sample_count = sc;
      return e;
   endfunction

   // Monitor: compare a full result set on each rising edge of done.
   always @(negedge clk) begin
      if (done && !done_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: done rose with no result expected");
         end else begin
            mon_e = exp_q.pop_front();
            check("sum_abs_err",  64'(sum_abs_err),  64'(mon_e.sum));
            check("max_err",      64'(max_err),      64'(mon_e.max_err));
            check("max_a",        64'(max_a),        64'(mon_e.max_a));
            check("max_b",        64'(max_b),        64'(mon_e.max_b));
            check("err_count",    64'(err_count),    64'(mon_e.err_count));
            check("sample_count", 64'(sample_count), 64'(mon_e.sample_count));
         end
      end
      done_prev = done;
   end

   // Called just after a rising edge; returns just after the edge that samples start.
   task automatic start_campaign(input logic [23:0] n);
      num_samples = n;
      start       = 1'b1;
      @(posedge clk); #1;
      start       = 1'b0;
   endtask

   task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic [15:0] xp);
      int n = 0;
      a = xa; b = xb; p_approx = xp; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready got 0 expected 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      @(negedge clk);
      while (!done && n < 20) begin
         n++;
         @(negedge clk);
      end
      check({name, "_done"}, 64'(done), 64'(1));
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  bp_a [6];
      logic [7:0]  bp_b [6];
      logic [15:0] bp_p [6];
      bit          d_seen [6];
      int          hs_cnt;

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0;
      a = '0; b = '0; p_approx = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy",         64'(busy),         64'(0));
      check("rst_done",         64'(done),         64'(0));
      check("rst_in_ready",     64'(in_ready),     64'(0));
      check("rst_sum_abs_err",  64'(sum_abs_err),  64'(0));
      check("rst_max_err",      64'(max_err),      64'(0));
      check("rst_sample_count", 64'(sample_count), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      // Exact products: all statistics stay zero.
      exp_q.push_back(mk(40'd0, 16'd0, 8'd0, 8'd0, 24'd0, 24'd4));
      start_campaign(24'd4);
      send(8'd3, 8'd5, 16'd15);
      send(8'd255, 8'd255, 16'd65025);
      send(8'd0, 8'd7, 16'd0);
      send(8'd128, 8'd2, 16'd256);
      wait_done("exact");

      // Single under-estimate: 20000 - 19000.
      exp_q.push_back(mk(40'd1000, 16'd1000, 8'd200, 8'd100, 24'd1, 24'd1));
      start_campaign(24'd1);
      send(8'd200, 8'd100, 16'd19000);
      wait_done("single");

      // Over- and under-estimates all of error 10, one idle cycle upstream; first wins the tie.
      exp_q.push_back(mk(40'd30, 16'd10, 8'd10, 8'd10, 24'd3, 24'd3));
      start_campaign(24'd3);
      send(8'd10, 8'd10, 16'd110);
      @(posedge clk); #1;
      send(8'd20, 8'd1, 16'd10);
      send(8'd5, 8'd5, 16'd15);
      wait_done("tie");

      // Back-pressure: valid held 6 cycles, only the first 3 accepted (errors 1, 0, 6).
      bp_a = '{8'd1, 8'd3, 8'd4, 8'd255, 8'd255, 8'd255};
      bp_b = '{8'd2, 8'd3, 8'd4, 8'd255, 8'd255, 8'd255};
      bp_p = '{16'd3, 16'd9, 16'd10, 16'd0, 16'd0, 16'd0};
      exp_q.push_back(mk(40'd7, 16'd6, 8'd4, 8'd4, 24'd2, 24'd3));
      start_campaign(24'd3);
      hs_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         a = bp_a[i]; b = bp_b[i]; p_approx = bp_p[i]; in_valid = 1'b1;
         @(negedge clk);
         if (in_valid && in_ready) hs_cnt++;
         if (i == 3) check("bp_ready_low_after_third", 64'(in_ready), 64'(0));
         d_seen[i] = done;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp_handshakes", 64'(hs_cnt), 64'(3));
      check("bp_done_low_edge1", 64'(d_seen[4]), 64'(0));
      check("bp_done_low_edge2", 64'(d_seen[5]), 64'(0));
      @(negedge clk);
      check("bp_done_edge3", 64'(done), 64'(1));
      @(posedge clk); #1;

      // Zero-length campaign with valid held high: never ready, done after one RUN cycle.
      exp_q.push_back(mk(40'd0, 16'd0, 8'd0, 8'd0, 24'd0, 24'd0));
      a = 8'd9; b = 8'd9; p_approx = 16'd0; in_valid = 1'b1;
      start_campaign(24'd0);
      @(negedge clk);
      check("zero_busy",     64'(busy),     64'(1));
      check("zero_done_low", 64'(done),     64'(0));
      check("zero_ready",    64'(in_ready), 64'(0));
      @(negedge clk);
      check("zero_done",       64'(done),     64'(1));
      check("zero_ready_done", 64'(in_ready), 64'(0));
      in_valid = 1'b0;
      @(posedge clk); #1;

      // Abort after 2 of 5 samples; in-flight samples must vanish.
      start_campaign(24'd5);
      send(8'd1, 8'd1, 16'd0);
      send(8'd2, 8'd2, 16'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy",         64'(busy),         64'(0));
      check("abort_done",         64'(done),         64'(0));
      check("abort_in_ready",     64'(in_ready),     64'(0));
      check("abort_sum_abs_err",  64'(sum_abs_err),  64'(0));
      check("abort_max_err",      64'(max_err),      64'(0));
      check("abort_sample_count", 64'(sample_count), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_err_count_held", 64'(err_count), 64'(0));
      @(posedge clk); #1;

      // Restart after abort: worst possible error.
      exp_q.push_back(mk(40'd65025, 16'd65025, 8'd255, 8'd255, 24'd1, 24'd1));
      start_campaign(24'd1);
      send(8'd255, 8'd255, 16'd0);
      wait_done("restart");

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
